uart_byte_receiver: RTL
=======================

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port DATA  output  8  last correctly received byte, LSB = first data bit.
REQ-007 SHALL have port VALID  output  1  one-CLK pulse; DATA newly updated.
REQ-008 SHALL have port FRAME_ERR  output  1  one-CLK pulse; stop bit sampled low.
REQ-009 SHALL have port PARITY_ERR  output  1  one-CLK pulse; parity mismatch.
REQ-010 SHALL have port BUSY  output  1  high from start-bit detection until return to IDLE.

Function
REQ-011 SHALL pass RX through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-012 SHALL generate an oversample tick, 1 CLK wide, every DIV = floor(CLK_FREQ/(BAUD*16)) CLK cycles (50 MHz / 9600 -> DIV = 325).
REQ-013 SHALL clear the tick divider on start-bit detection, aligning sampling to the falling edge.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: SHALL go to START on a synchronized 1->0 transition of RX.
REQ-016 START: SHALL re-sample RX after 8 ticks (mid-bit); low -> DATA; high -> IDLE (glitch reject), no pulse output.
REQ-017 DATA: SHALL sample RX every 16 ticks, 8 bits, LSB first, into an internal shift register; DATA is unchanged during reception.
REQ-018 After the 8th bit, SHALL go to PARITY when parity is enabled, otherwise to STOP.
REQ-019 STOP: SHALL sample RX 16 ticks after the last bit; high -> load DATA and pulse VALID; low -> pulse FRAME_ERR and leave DATA unchanged.
REQ-020 SHALL return to IDLE in the same cycle as the stop sample, so a start bit arriving immediately after the mid-stop point is detected.
REQ-021 Latency: VALID/FRAME_ERR SHALL assert exactly one CLK after the stop-bit sample tick.
REQ-022 VALID, FRAME_ERR and PARITY_ERR SHALL be mutually exclusive and never high for more than one CLK.
REQ-023 An RX held low for the whole frame (break) SHALL yield FRAME_ERR only, then wait in IDLE for RX high before re-arming.

Reset
REQ-024 While RST is high, SHALL force state IDLE, DATA=8'h00, VALID=0, FRAME_ERR=0, PARITY_ERR=0, BUSY=0, divider and bit counter 0, and synchronizer stages to 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse output; reception resumes at the next falling edge after RST is released.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: SHALL expect one even-parity bit after the data bits; on mismatch SHALL pulse PARITY_ERR in place of VALID and leave DATA unchanged; the stop bit is still checked, and FRAME_ERR takes priority.
REQ-027 Macro UART_RX_PARITY_EN undefined: SHALL omit the PARITY state, and PARITY_ERR SHALL be tied 0.

Structure
REQ-028 The shared package SHALL hold the state enumeration, the oversample ratio constant (16), and the data width constant (8).
REQ-029 The tick generator SHALL be a sub-module uart_baud_tick (parameters CLK_FREQ, BAUD; ports CLK, RST, CLR, TICK).

Verification
REQ-030 Send 0x55 at 9600 baud, 50 MHz clock -> one VALID pulse, DATA=0x55, no error pulses.
REQ-031 Send 0xA3 then 0x0F back-to-back with a one-bit stop -> two VALID pulses; DATA=0xA3 then 0x0F.
REQ-032 Drive a 3-tick low glitch on an idle RX -> no outputs, BUSY returns to 0 within 9 ticks.
REQ-033 Send 0x3C with the stop bit low -> FRAME_ERR pulse, no VALID pulse, DATA keeps its previous value.
REQ-034 Assert RST after the 4th data bit of 0xFF, then send 0x81 -> no pulse for the aborted frame; VALID with DATA=0x81.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with the parity bit set to 0 -> PARITY_ERR pulse, no VALID pulse; send with the parity bit set to 1 -> VALID, DATA=0x07.

Source files
------------

// File: rtl/uart_byte_receiver_pkg.sv
// Shared constants and FSM state type for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state to the enumeration.
package uart_byte_receiver_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_W     = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    function automatic int calc_div(int clk_freq, int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-CLK TICK every floor(CLK_FREQ/(BAUD*16)) cycles.
// CLR restarts the period so sampling aligns to the start-bit edge.
module uart_baud_tick
    import uart_byte_receiver_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int DIV_RAW = calc_div(CLK_FREQ, BAUD);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign TICK = (cnt == CW'(DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (CLR || TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: 16x oversampled 8N1 frame decoder with one-CLK result pulses.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    output logic              FRAME_ERR,
    output logic              PARITY_ERR,
    output logic              BUSY,
    output state_t            DBG_STATE
);

    localparam int TCW = $clog2(OVERSAMPLE);

    // Handshake: VALID, FRAME_ERR and PARITY_ERR are single-cycle strobes with no
    // back-pressure; DATA is only written in the cycle VALID rises and holds otherwise.

    logic              rx_s1, rx_s2, rx_prev;
    logic              fall;
    logic              tick;
    logic              div_clr;
    logic              half_tick, last_tick;
    logic              stop_sample;
    logic              par_ok;
    logic [TCW-1:0]    tick_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift;
    state_t            state, state_next;

    uart_baud_tick #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .CLR (div_clr),
        .TICK(tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Edge-based arming: after a break the line must rise before a new start counts.
    assign fall      = rx_prev & ~rx_s2;
    assign half_tick = tick && (tick_cnt == TCW'(OVERSAMPLE / 2 - 1));
    assign last_tick = tick && (tick_cnt == TCW'(OVERSAMPLE - 1));

    always_comb begin
        state_next  = state;
        div_clr     = 1'b0;
        stop_sample = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_next = ST_START;
                    div_clr    = 1'b1;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    state_next = rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_tick && (bit_cnt == 3'(DATA_W - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (last_tick) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (last_tick) begin
                    state_next  = ST_IDLE;
                    stop_sample = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if ((state == ST_IDLE) || (state != state_next)) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + TCW'(1);
            end
            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (last_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if ((state == ST_DATA) && last_tick) begin
                shift <= {rx_s2, shift[DATA_W-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_bit <= 1'b0;
        end else if ((state == ST_PARITY) && last_tick) begin
            par_bit <= rx_s2;
        end
    end

    assign par_ok = ~^{shift, par_bit};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PARITY_ERR <= 1'b0;
        end else begin
            PARITY_ERR <= stop_sample && rx_s2 && !par_ok;
        end
    end
`else
    assign par_ok     = 1'b1;
    assign PARITY_ERR = 1'b0;
`endif

    // Frame error wins over parity: a low stop bit never yields PARITY_ERR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            VALID     <= stop_sample && rx_s2 && par_ok;
            FRAME_ERR <= stop_sample && !rx_s2;
            if (stop_sample && rx_s2 && par_ok) begin
                DATA <= shift;
            end
        end
    end

    assign BUSY      = (state != ST_IDLE);
    assign DBG_STATE = state;

endmodule
